// File: rtl/cm_serial_ctrl.sv
// Sequencing controller for a serial multiply-accumulate PE. It streams operand
// pairs into the PE, waits out the PE latency, then offers the dot product.
module cm_serial_ctrl #(
    parameter int DW     = 8,
    parameter int LEN_W  = 4,
    parameter int PE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_a,
    input  logic [DW-1:0]    in_b,
    output logic [DW-1:0]    pe_a,
    output logic [DW-1:0]    pe_b,
    output logic             pe_mux_reset,
    input  logic [DW-1:0]    pe_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic             busy
);

    localparam int                 DRAIN_W    = $clog2(PE_LAT + 2);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_LAT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_e;

    state_e             state_q,        state_d;
    logic [LEN_W-1:0]   len_q,          len_d;
    logic [LEN_W-1:0]   cnt_q,          cnt_d;
    logic [DRAIN_W-1:0] drain_q,        drain_d;
    logic [DW-1:0]      pe_a_q,         pe_a_d;
    logic [DW-1:0]      pe_b_q,         pe_b_d;
    logic               pe_mux_reset_q, pe_mux_reset_d;
    logic [DW-1:0]      res_data_q,     res_data_d;
    logic               in_ready_q,     in_ready_d;
    logic               res_valid_q,    res_valid_d;
    logic               busy_q,         busy_d;

    logic               xfer;

    // in_ready_q is high exactly while the FSM sits in RUN.
    assign xfer = in_valid && in_ready_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        drain_d        = drain_q;
        pe_a_d         = '0;
        pe_b_d         = '0;
        pe_mux_reset_d = 1'b0;
        res_data_d     = res_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = RUN;
                        len_d   = len;
                        cnt_d   = '0;
                    end else begin
                        state_d    = HOLD;
                        res_data_d = '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    pe_a_d         = in_a;
                    pe_b_d         = in_b;
                    pe_mux_reset_d = (cnt_q == '0);
                    cnt_d          = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end
            end
            DRAIN: begin
                // Zero operands flush the last pair through the PE pipeline.
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d    = HOLD;
                    res_data_d = pe_out;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == RUN);
        res_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and they all update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            len_q          <= '0;
            cnt_q          <= '0;
            drain_q        <= '0;
            pe_a_q         <= '0;
            pe_b_q         <= '0;
            pe_mux_reset_q <= 1'b0;
            res_data_q     <= '0;
            in_ready_q     <= 1'b0;
            res_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            drain_q        <= drain_d;
            pe_a_q         <= pe_a_d;
            pe_b_q         <= pe_b_d;
            pe_mux_reset_q <= pe_mux_reset_d;
            res_data_q     <= res_data_d;
            in_ready_q     <= in_ready_d;
            res_valid_q    <= res_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign pe_a         = pe_a_q;
    assign pe_b         = pe_b_q;
    assign pe_mux_reset = pe_mux_reset_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_cm_serial_ctrl.sv
// Directed bench for cm_serial_ctrl with a behavioural serial MAC PE
// (acc <= mux_reset ? a*b : acc + a*b, one cycle of latency).
module tb_cm_serial_ctrl;

    localparam int DW     = 8;
    localparam int LEN_W  = 4;
    localparam int PE_LAT = 1;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             start     = 1'b0;
    logic [LEN_W-1:0] len       = '0;
    logic             abort     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_a      = '0;
    logic [DW-1:0]    in_b      = '0;
    logic [DW-1:0]    pe_a;
    logic [DW-1:0]    pe_b;
    logic             pe_mux_reset;
    logic [DW-1:0]    pe_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [DW-1:0]    res_data;
    logic             busy;

    logic [DW-1:0]    acc;

    int checks = 0;
    int errors = 0;

    cm_serial_ctrl #(
        .DW     (DW),
        .LEN_W  (LEN_W),
        .PE_LAT (PE_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .pe_a         (pe_a),
        .pe_b         (pe_b),
        .pe_mux_reset (pe_mux_reset),
        .pe_out       (pe_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (pe_mux_reset) begin
            acc <= pe_a * pe_b;
        end else begin
            acc <= acc + pe_a * pe_b;
        end
    end

    assign pe_out = acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},      32'(busy),         0);
        check({tag, " in_ready"},  32'(in_ready),     0);
        check({tag, " pe_a"},      32'(pe_a),         0);
        check({tag, " pe_b"},      32'(pe_b),         0);
        check({tag, " mux_reset"}, 32'(pe_mux_reset), 0);
        check({tag, " res_valid"}, 32'(res_valid),    0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset res_data", 32'(res_data), 0);
        rst = 1'b1;
        tick();

        // Back-to-back vector (3,2),(2,5),(5,3) -> 31
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        check("run busy", 32'(busy), 1);
        check("run in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd2;
        tick();
        check("p1 pe_a", 32'(pe_a), 3);
        check("p1 pe_b", 32'(pe_b), 2);
        check("p1 mux_reset", 32'(pe_mux_reset), 1);
        in_a = 8'd2; in_b = 8'd5;
        tick();
        check("p2 pe_a", 32'(pe_a), 2);
        check("p2 mux_reset", 32'(pe_mux_reset), 0);
        in_a = 8'd5; in_b = 8'd3;
        tick();
        check("p3 pe_b", 32'(pe_b), 3);
        check("p3 mux_reset", 32'(pe_mux_reset), 0);
        check("drain in_ready", 32'(in_ready), 0);
        in_valid = 1'b0; in_a = 8'd9; in_b = 8'd9;
        tick();
        check("drain pe_a", 32'(pe_a), 0);
        check("drain res_valid", 32'(res_valid), 0);
        tick();
        check("vec1 res_valid", 32'(res_valid), 1);
        check("vec1 res_data", 32'(res_data), 31);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("vec1 ack res_valid", 32'(res_valid), 0);
        check("vec1 ack busy", 32'(busy), 0);

        // Same vector with two idle cycles between pairs
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd2;
        tick();
        check("gap p1 mux_reset", 32'(pe_mux_reset), 1);
        in_valid = 1'b0; in_a = 8'd7; in_b = 8'd7;
        tick();
        check("gap1 pe_a", 32'(pe_a), 0);
        check("gap1 pe_b", 32'(pe_b), 0);
        check("gap1 mux_reset", 32'(pe_mux_reset), 0);
        check("gap1 in_ready", 32'(in_ready), 1);
        tick();
        check("gap2 pe_a", 32'(pe_a), 0);
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd5;
        tick();
        check("gap p2 pe_a", 32'(pe_a), 2);
        check("gap p2 mux_reset", 32'(pe_mux_reset), 0);
        in_valid = 1'b0;
        repeat (2) tick();
        check("gap3 pe_b", 32'(pe_b), 0);
        in_valid = 1'b1; in_a = 8'd5; in_b = 8'd3;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("vec2 res_valid", 32'(res_valid), 1);
        check("vec2 res_data", 32'(res_data), 31);

        // Result held under back-pressure; start during HOLD ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); len = 4'd1;
            tick();
            check("hold res_valid", 32'(res_valid), 1);
            check("hold res_data", 32'(res_data), 31);
            check("hold in_ready", 32'(in_ready), 0);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("hold abort ignored", 32'(res_valid), 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("hold ack busy", 32'(busy), 0);

        // Fresh job: (12,5) -> 60, no carry-over of 31
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd12; in_b = 8'd5;
        tick();
        in_valid = 1'b0;
        check("len1 mux_reset", 32'(pe_mux_reset), 1);
        check("len1 in_ready", 32'(in_ready), 0);
        repeat (2) tick();
        check("len1 res_valid", 32'(res_valid), 1);
        check("len1 res_data", 32'(res_data), 60);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("len1 ack res_valid", 32'(res_valid), 0);

        // Back-to-back start with len=0 -> immediate zero result, PE untouched
        start = 1'b1; len = 4'd0;
        tick();
        start = 1'b0;
        check("len0 res_valid", 32'(res_valid), 1);
        check("len0 res_data", 32'(res_data), 0);
        check("len0 busy", 32'(busy), 1);
        check("len0 mux_reset", 32'(pe_mux_reset), 0);
        tick();
        check("len0 pe_acc", 32'(acc), 60);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Wrap: (16,16),(0,0) -> 256 mod 256 = 0
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd16; in_b = 8'd16;
        tick();
        in_a = 8'd0; in_b = 8'd0;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("wrap res_valid", 32'(res_valid), 1);
        check("wrap res_data", 32'(res_data), 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Abort mid-RUN, with a pair offered in the same cycle
        start = 1'b1; len = 4'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
        tick();
        check("abort pre busy", 32'(busy), 1);
        abort = 1'b1; in_a = 8'd1; in_b = 8'd1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check_idle("abort");
        repeat (4) tick();
        check("abort no result", 32'(res_valid), 0);

        // Reset mid-HOLD clears the held result asynchronously
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("rsthold res_data", 32'(res_data), 12);
        #2 rst = 1'b0;
        #1;
        check_idle("rst hold");
        check("rst hold res_data", 32'(res_data), 0);
        tick();
        rst = 1'b1;
        tick();

        // Reset mid-RUN
        start = 1'b1; len = 4'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd4; in_b = 8'd4;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_idle("rst run");
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check_idle("post rst");

        // Recovery job after reset: (2,3) -> 6
        start = 1'b1; len = 4'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("recover res_data", 32'(res_data), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
